// File: rtl/cnt_mon_pkg.sv
// Shared types and constants for the counter event monitor.
package cnt_mon_pkg;

   localparam int CNT_W = 4;
   localparam int EVT_W = 2 + CNT_W;

   typedef enum logic [1:0] {
      EVT_NONE = 2'b00,
      EVT_WRAP = 2'b01,
      EVT_SKIP = 2'b10,
      EVT_LOAD = 2'b11
   } evt_type_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_TRACK
   } state_t;

   // Expected successor of a counter value; wraps naturally in CNT_W bits.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] v);
      return v + 1'b1;
   endfunction

endpackage

// File: rtl/cnt_evt_fifo.sv
// Small synchronous event FIFO; pointers carry an extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module cnt_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         push_ok;
   logic         pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);

   // Head is forced to zero while empty so idle outputs read as a null event.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cnt_event_monitor.sv
// Observer for the 4-bit free-running counter: classifies each sample as
// WRAP, SKIP or completed LOAD and queues the events for a consumer.
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_IDLE  | no valid previous sample yet
//   S_LOAD  | counter preset load in progress
//   S_TRACK | checking each sample against prev + 1
module cnt_event_monitor
   import cnt_mon_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic              cnt_load,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [1:0]        evt_type,
   output logic [CNT_W-1:0]  evt_value,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              skip_err,
   output logic              ovf_err
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] prev;
   logic [CNT_W-1:0] prev_nxt;
   logic             evt_push;
   evt_type_t        evt_kind;
   logic [CNT_W-1:0] evt_val;
   logic [EVT_W-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             evt_pop;
   logic             drop;

   assign evt_valid = !fifo_empty;
   assign evt_pop   = evt_valid && evt_ready;
   assign evt_type  = fifo_dout[EVT_W-1 -: 2];
   assign evt_value = fifo_dout[CNT_W-1:0];
   assign drop      = evt_push && fifo_full && !evt_pop;

   // State and last-sample registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         prev  <= '0;
      end else begin
         state <= state_nxt;
         prev  <= prev_nxt;
      end
   end

   // Classifier: next state, prev capture and at most one event per cycle.
   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      evt_push  = 1'b0;
      evt_kind  = EVT_NONE;
      evt_val   = '0;
      case (state)
         S_IDLE: begin
            if (cnt_load) begin
               state_nxt = S_LOAD;
            end else begin
               prev_nxt  = cnt_in;
               state_nxt = S_TRACK;
            end
         end
         S_LOAD: begin
            if (!cnt_load) begin
               evt_push  = 1'b1;
               evt_kind  = EVT_LOAD;
               evt_val   = cnt_in;
               prev_nxt  = cnt_in;
               state_nxt = S_TRACK;
            end
         end
         S_TRACK: begin
            prev_nxt = cnt_in;
            if (cnt_load) begin
               state_nxt = S_LOAD;
            end else if (cnt_in == cnt_next(prev)) begin
               if (prev == '1) begin
                  evt_push = 1'b1;
                  evt_kind = EVT_WRAP;
                  evt_val  = '0;
               end
            end else begin
               evt_push = 1'b1;
               evt_kind = EVT_SKIP;
               evt_val  = cnt_in;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Health summary; a wrap is counted even when its event is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_count <= '0;
         skip_err   <= 1'b0;
         ovf_err    <= 1'b0;
      end else begin
         if (evt_push && evt_kind == EVT_WRAP && wrap_count != '1)
            wrap_count <= wrap_count + 1'b1;
         if (evt_push && evt_kind == EVT_SKIP) skip_err <= 1'b1;
         if (drop) ovf_err <= 1'b1;
      end
   end

   cnt_evt_fifo #(
      .DEPTH (DEPTH),
      .W     (EVT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (evt_push),
      .din   ({evt_kind, evt_val}),
      .pop   (evt_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: doc/cnt_event_monitor.md
# cnt_event_monitor

Downstream observer for the 4-bit free-running counter. Each clock it samples the counter value and checks that the value advanced by exactly +1 modulo 16. It classifies each sample as a wrap, a skip, or a completed preset load, and queues these events into a small FIFO. The FIFO is drained over a valid/ready handshake. A saturating wrap counter and sticky error flags give software a cheap health summary of the counter stage.

## Interface
Parameters:
- DEPTH, 4: event FIFO entries; power of two, 2..16.
- WRAP_W, 8: width of the wrap counter.

Ports:
- clk  in  1  rising-edge clock, shared with the counter stage.
- rst  in  1  synchronous, active-high reset.
- cnt_in  in  4  counter value, stable across each rising clk edge.
- cnt_load  in  1  high while the counter is being loaded with its preset; mirrors the counter's reset.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head.
- evt_type  out  2  event type: 01 WRAP, 10 SKIP, 11 LOAD; 00 is never emitted.
- evt_value  out  4  cnt_in value sampled with the event.
- wrap_count  out  WRAP_W  number of wraps; saturates at all-ones.
- skip_err  out  1  sticky; set on any SKIP event.
- ovf_err  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Registers: prev[3:0] holds the last sampled cnt_in.
- FSM states:
  - S_IDLE: no valid prev.
  - S_LOAD: preset load in progress.
  - S_TRACK: normal checking.
- FSM transitions:
  - S_IDLE, cnt_load=1: go to S_LOAD.
  - S_IDLE, cnt_load=0: capture prev, go to S_TRACK, no event.
  - S_LOAD, cnt_load=1: stay in S_LOAD, no event.
  - S_LOAD, cnt_load=0: push LOAD with evt_value=cnt_in, capture prev, go to S_TRACK.
  - S_TRACK, cnt_load=1: go to S_LOAD, no event.
  - S_TRACK, cnt_in == prev+1 (4-bit wrap) and prev == 15: push WRAP with value 0; increment wrap_count (saturating).
  - S_TRACK, cnt_in == prev+1, no wrap: no event.
  - S_TRACK, any other cnt_in (including cnt_in == prev): push SKIP with value cnt_in; set skip_err.
  - In S_TRACK, prev is updated every cycle.
- At most one event is generated per cycle.
- FIFO push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the event is dropped and ovf_err is set.
  - A dropped WRAP still increments wrap_count.
- Pop occurs when evt_valid && evt_ready.
  - evt_type and evt_value stay stable while evt_valid && !evt_ready.
- Width rules:
  - Pointers are log2(DEPTH)+1 bits, with an MSB wrap bit for full/empty detection.
  - prev+1 is computed in 4 bits.
- Sticky flags clear only on rst.

## Timing
- Reset values (rst sampled high at an edge):
  - state=S_IDLE, prev=0, FIFO empty.
  - evt_valid=0, evt_type=00, evt_value=0.
  - wrap_count=0, skip_err=0, ovf_err=0.
- rst overrides everything in that cycle: no push, no pop, in-flight FIFO contents are discarded.
- Event latency: cnt_in is sampled at edge N; the event is written at edge N; evt_valid is high after edge N, i.e. 1 cycle. There is no combinational path from cnt_in to evt_*.
- wrap_count and skip_err update at the same edge as the push.
- evt_ready to pop is effective at the same edge. evt_ready has no combinational path to evt_valid, except through the registered FIFO state.
- A back-to-back stream of one pop per cycle is sustained indefinitely when DEPTH >= 2.

## Structure
- Shared package cnt_mon_pkg:
  - evt_type_t with values EVT_WRAP=2'b01, EVT_SKIP=2'b10, EVT_LOAD=2'b11.
  - state_t with values S_IDLE, S_LOAD, S_TRACK.
  - CNT_W=4.
- One sub-module, cnt_evt_fifo: synchronous FIFO parameterised on DEPTH and data width 6, with push/pop/full/empty.
- Classifier FSM, wrap counter and sticky flags live in the top module.

## Test plan
- Reset, then cnt_in runs 3,4,...,15,0,1 with evt_ready=1: exactly one WRAP (value 0); wrap_count=1; skip_err=0.
- cnt_in sequence 5,6,9,10: one SKIP with value 9; skip_err=1 and stays 1 until rst.
- cnt_load=1 for 3 cycles with cnt_in=0xA, then released with cnt_in=0xA,0xB: one LOAD event with value 0xA, then no further events.
- evt_ready=0 and DEPTH=4, force 6 SKIPs: FIFO holds the first 4; ovf_err=1. Then raise evt_ready: 4 events drain in order over 4 cycles, after which evt_valid=0.
- FIFO full with evt_ready=1 and a new SKIP in the same cycle: push accepted, no overflow, occupancy stays 4.
- rst asserted with 2 events queued and wrap_count=3: next cycle evt_valid=0, wrap_count=0, state S_IDLE, and the first post-reset sample produces no event.
